// File: rtl/can_bit_sampler.sv
// CAN bit timing and sampling: rx synchronizer, tq prescaler, SYNC/SEG1/SEG2
// bit FSM with hard sync and resync, single or triple sampling, bus idle.
module can_bit_sampler #(
  parameter int BRP_W = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             rxIn,
  input  logic [BRP_W-1:0] brp,
  input  logic [4:0]       tseg1,
  input  logic [3:0]       tseg2,
  input  logic [2:0]       sjw,
  input  logic             rateSelector,
  output logic             samplePulse,
  output logic             dOut,
  output logic             bitValid,
  output logic             busIdle
);

  typedef enum logic [1:0] {SYNC, SEG1, SEG2} st_e;

  st_e              state_q, state_d;
  logic [4:0]       tqc_q, tqc_d;
  logic [BRP_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [BRP_W-1:0] brp_q;
  logic [4:0]       tseg1_q;
  logic [3:0]       tseg2_q;
  logic [2:0]       sjw_q;
  logic             tri_q;
  logic             load_q, load_d;
  logic [2:0]       ext_q;
  logic [3:0]       shr_q;
  logic             rsd_q;
  logic [2:0]       samp_q;
  logic             dout_q, bv_q;
  logic [3:0]       rc_q;

  logic [BRP_W-1:0] brp_e;
  logic [4:0]       tseg1_e;
  logic [3:0]       tseg2_e;
  logic [2:0]       sjw_e;
  logic             tri_e;
  logic             tq_end, edge_w, idle, hsync;
  logic             rs1, rs2, last1, in_win, seg2_last;
  logic [5:0]       seg1_len;
  logic [2:0]       ext_new;
  logic [4:0]       rem, rm1;
  logic [3:0]       shr_new, shr_e;
  logic             new_bit, maj;

  // First clk of each bit uses live config, later clks the latched copy.
  assign brp_e   = load_q ? brp : brp_q;
  assign tseg1_e = load_q ? tseg1 : tseg1_q;
  assign tseg2_e = load_q ? tseg2 : tseg2_q;
  assign sjw_e   = load_q ? sjw : sjw_q;
  assign tri_e   = load_q ? rateSelector : tri_q;

  assign tq_end = (cnt_q == brp_e);
  assign edge_w = prev_q & ~sync2_q;
  assign idle   = (rc_q == 4'd11);
  assign hsync  = edge_w & idle;
  assign rs1    = edge_w & ~idle & dout_q & ~rsd_q & (state_q == SEG1);
  assign rs2    = edge_w & ~idle & dout_q & ~rsd_q & (state_q == SEG2);

  assign seg1_len = 6'(tseg1_e) + 6'(ext_q);
  assign last1    = (state_q == SEG1) && (6'(tqc_q) + 6'd1 == seg1_len);
  assign in_win   = tri_e ? (6'(tqc_q) + 6'd3 >= seg1_len) : last1;
  assign ext_new  = (tqc_q + 5'd1 < 5'(sjw_e)) ? 3'(tqc_q + 5'd1) : sjw_e;

  assign rem       = 5'(tseg2_e) - 5'(shr_q) - tqc_q;
  assign rm1       = rem - 5'd1;
  assign shr_new   = (rm1 <= 5'(sjw_e)) ? 4'(rm1) : 4'(sjw_e);
  assign shr_e     = rs2 ? shr_new : shr_q;
  assign seg2_last = (tqc_q + 5'd1 + 5'(shr_e) >= 5'(tseg2_e));

  assign maj     = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync2_q) |
                   (samp_q[0] & sync2_q);
  assign new_bit = tri_e ? maj : sync2_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= SYNC;
      tqc_q   <= '0;
    end else begin
      state_q <= state_d;
      tqc_q   <= tqc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tqc_d   = tqc_q;
    load_d  = 1'b0;
    if (hsync) begin
      state_d = SYNC;
      tqc_d   = '0;
      load_d  = 1'b1;
    end else if (tq_end) begin
      unique case (state_q)
        SYNC: begin
          state_d = SEG1;
          tqc_d   = '0;
        end
        SEG1: begin
          if (last1) begin
            state_d = SEG2;
            tqc_d   = '0;
          end else begin
            tqc_d = tqc_q + 5'd1;
          end
        end
        SEG2: begin
          if (seg2_last) begin
            state_d = SYNC;
            tqc_d   = '0;
            load_d  = 1'b1;
          end else begin
            tqc_d = tqc_q + 5'd1;
          end
        end
        default: begin
          state_d = SYNC;
          tqc_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    samplePulse = (state_q == SEG1) & tq_end & in_win;
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (hsync || tq_end) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      load_q  <= 1'b1;
      brp_q   <= '0;
      tseg1_q <= '0;
      tseg2_q <= '0;
      sjw_q   <= '0;
      tri_q   <= 1'b0;
      ext_q   <= '0;
      shr_q   <= '0;
      rsd_q   <= 1'b0;
      samp_q  <= 3'b111;
      dout_q  <= 1'b1;
      bv_q    <= 1'b0;
      rc_q    <= 4'd11;
    end else begin
      sync1_q <= rxIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      bv_q    <= 1'b0;
      if (load_q) begin
        brp_q   <= brp;
        tseg1_q <= tseg1;
        tseg2_q <= tseg2;
        sjw_q   <= sjw;
        tri_q   <= rateSelector;
      end
      if (load_d) begin
        ext_q <= '0;
        shr_q <= '0;
        rsd_q <= 1'b0;
      end else if (rs1) begin
        ext_q <= ext_new;
        rsd_q <= 1'b1;
      end else if (rs2) begin
        shr_q <= shr_new;
        rsd_q <= 1'b1;
      end
      if (hsync) begin
        samp_q <= 3'b111;
        rc_q   <= '0;
      end else if (samplePulse) begin
        samp_q <= {samp_q[1:0], sync2_q};
        if (last1) begin
          dout_q <= new_bit;
          bv_q   <= 1'b1;
          if (!new_bit) rc_q <= '0;
          else if (!idle) rc_q <= rc_q + 4'd1;
        end
      end
    end
  end

  assign dOut     = dout_q;
  assign bitValid = bv_q;
  assign busIdle  = idle;

endmodule
